// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with whole-scan debounce,
// single-key press events and a 4-deep valid/ready output FIFO.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       multi_key,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [2:0] fifo_count
);
  localparam int DW = $clog2(SETTLE_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, DRIVE} state_t;
  state_t        r_state, w_state_nx;
  logic [1:0]    r_col, w_col_nx;
  logic [DW-1:0] r_dwell, w_dwell_nx;
  logic          w_sample, w_scan_done;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nx;
      r_col   <= w_col_nx;
      r_dwell <= w_dwell_nx;
    end

  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_dwell_nx = r_dwell;
    w_sample   = 1'b0;
    if (!enable) begin
      w_state_nx = IDLE;
      w_col_nx   = '0;
      w_dwell_nx = '0;
    end else if (r_state == IDLE) begin
      w_state_nx = DRIVE;
    end else if (r_dwell == DWELL_LAST) begin
      w_sample   = 1'b1;
      w_col_nx   = r_col + 2'd1;
      w_dwell_nx = '0;
    end else
      w_dwell_nx = r_dwell + DW'(1);
  end

  assign cols        = (r_state == DRIVE) ? 4'b0001 << r_col : 4'h0;
  assign w_scan_done = w_sample && (r_col == 2'd3);

  // columns 0..2 shift in from the top, so column 3 completes the snapshot live
  logic [11:0]   r_snap;
  logic [15:0]   r_prev, r_deb, w_new;
  logic [SW-1:0] r_stable, w_stable_nx;
  logic          w_load, w_onehot, r_push;
  logic [3:0]    w_idx, r_push_code;

  assign w_new       = {rows, r_snap};
  assign w_stable_nx = (w_new != r_prev) ? SW'(1) : (r_stable == STABLE_MAX) ? r_stable : r_stable + SW'(1);
  assign w_load      = w_scan_done && (w_stable_nx == STABLE_MAX);
  assign w_onehot    = (w_new != 16'h0) && ((w_new & (w_new - 16'h1)) == 16'h0);

  always_comb begin
    w_idx = 4'h0;
    for (int i = 0; i < 16; i++) if (w_new[i]) w_idx = 4'(i);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_snap      <= '0;
      r_prev      <= '0;
      r_stable    <= '0;
      r_deb       <= '0;
      r_push      <= 1'b0;
      r_push_code <= '0;
    end else if (!enable) begin
      r_snap   <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_deb    <= '0;
      r_push   <= 1'b0;
    end else begin
      r_push      <= w_load && (r_deb == 16'h0) && w_onehot;
      r_push_code <= w_idx;
      if (w_sample) r_snap <= {rows, r_snap[11:4]};
      if (w_scan_done) begin
        r_prev   <= w_new;
        r_stable <= w_stable_nx;
      end
      if (w_load) r_deb <= w_new;
    end

  assign key_held  = |r_deb;
  assign multi_key = (r_deb & (r_deb - 16'h1)) != 16'h0;

  logic [3:0] r_mem [4];
  logic [1:0] r_wr, r_rd;
  logic [2:0] r_count;
  logic       r_ovf, w_pop, w_full, w_wr;

  assign w_pop  = key_valid && key_ready;
  assign w_full = r_count == 3'd4;
  assign w_wr   = r_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= r_push_code;
        r_wr        <= r_wr + 2'd1;
      end
      if (w_pop) r_rd <= r_rd + 2'd1;
      r_count <= r_count + {2'b00, w_wr} - {2'b00, w_pop};
      r_ovf   <= (r_push && w_full && !w_pop) || (r_ovf && !ovf_clr);
    end

  assign key_code   = r_mem[r_rd];
  assign key_valid  = r_count != 3'd0;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: randomized self-checking bench; expectations come from a
// scan-level model of the keypad, debounce history and a bounded code queue.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;
  localparam int SETTLE = 4;
  localparam int DEB = 2;
  localparam int SCAN_BOUND = 8 * SETTLE + 8;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, key_ready = 1'b0, ovf_clr = 1'b0;
  logic [3:0] rows, cols, key_code;
  logic key_valid, key_held, multi_key, overflow;
  logic [2:0] fifo_count;
  logic [15:0] keys = '0;
  int checks = 0, fails = 0;

  logic [15:0] m_hist[$];
  logic [15:0] m_deb = '0;
  logic [3:0] m_q[$];
  logic m_ovf = 1'b0, m_pend = 1'b0;
  logic [3:0] m_pend_code = '0;

  keypad_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .multi_key(multi_key), .overflow(overflow),
    .ovf_clr(ovf_clr), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // physical keypad: a pressed key shorts its column drive onto its row
  always_comb begin
    rows = 4'h0;
    for (int c = 0; c < 4; c++) if (cols[c]) rows = rows | keys[c*4 +: 4];
  end

  function automatic void model_commit(bit pop);
    if (pop && m_q.size() > 0) m_q.delete(0);
    if (m_pend) begin
      if (m_q.size() < 4) m_q.push_back(m_pend_code);
      else m_ovf = 1'b1;
      m_pend = 1'b0;
    end
  endfunction

  function automatic void model_clear_scan();
    model_commit(1'b0);
    m_hist.delete();
    m_deb = '0;
  endfunction

  function automatic void model_scan(logic [15:0] s);
    bit same = 1'b1;
    m_hist.push_back(s);
    if (m_hist.size() > DEB) m_hist.delete(0);
    foreach (m_hist[i]) if (m_hist[i] != s) same = 1'b0;
    if (m_hist.size() == DEB && same) begin
      if (m_deb == 16'h0 && $countones(s) == 1) begin
        m_pend = 1'b1;
        for (int i = 0; i < 16; i++) if (s[i]) m_pend_code = 4'(i);
      end
      m_deb = s;
    end
  endfunction

  // holds k for one whole scan; returns on the negedge after the scan-complete edge
  task automatic run_scan(input logic [15:0] k);
    int n = 0;
    model_commit(1'b0);
    keys = k;
    while (cols !== 4'h8 && n < SCAN_BOUND) begin @(negedge clk); n++; end
    while (cols === 4'h8 && n < SCAN_BOUND) begin @(negedge clk); n++; end
    checks++;
    if (n >= SCAN_BOUND) begin fails++; $display("FAIL scan_timeout: waited %0d cycles, limit %0d", n, SCAN_BOUND); end
    model_scan(k);
  endtask

  task automatic step();
    @(negedge clk);
    model_commit(1'b0);
  endtask

  task automatic press_release(input int k);
    run_scan(16'h1 << k);
    run_scan(16'h1 << k);
    run_scan(16'h0);
    run_scan(16'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cols !== 4'h0) begin fails++; $display("FAIL reset_cols: got %0h expected 0", cols); end
    checks++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_key_code: got %0h expected 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid: got %0b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_key_held: got %0b expected 0", key_held); end
    checks++; if (multi_key !== 1'b0) begin fails++; $display("FAIL reset_multi_key: got %0b expected 0", multi_key); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_press();
    enable = 1'b1;
    run_scan(16'h0040);
    step();
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL single_no_push_scan1: got %0d expected 0", fifo_count); end
    run_scan(16'h0040);
    checks++; if (key_valid !== 1'b0) begin fails++; $display("FAIL single_valid_latency: got %0b expected 0", key_valid); end
    checks++; if (key_held !== 1'b1) begin fails++; $display("FAIL single_key_held: got %0b expected 1", key_held); end
    step();
    checks++; if (key_valid !== 1'b1) begin fails++; $display("FAIL single_key_valid: got %0b expected 1", key_valid); end
    checks++; if (key_code !== 4'd6) begin fails++; $display("FAIL single_key_code: got %0d expected 6", key_code); end
    checks++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    m_q.delete(0);
    checks++; if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL single_pop: got valid=%0b count=%0d expected 0/0", key_valid, fifo_count); end
    run_scan(16'h0);
    run_scan(16'h0);
    checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL single_release_held: got %0b expected 0", key_held); end
  endtask

  task automatic test_bounce();
    repeat (4) begin
      run_scan(16'h0200);
      checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL bounce_held_on: got %0b expected 0", key_held); end
      run_scan(16'h0000);
      checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL bounce_held_off: got %0b expected 0", key_held); end
    end
    step();
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL bounce_no_push: got %0d expected 0", fifo_count); end
    run_scan(16'h0200);
    run_scan(16'h0200);
    step();
    checks++; if (fifo_count !== 3'd1 || key_code !== 4'd9) begin fails++; $display("FAIL bounce_push9: got count=%0d code=%0d expected 1/9", fifo_count, key_code); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    m_q.delete(0);
    run_scan(16'h0);
    run_scan(16'h0);
  endtask

  task automatic test_multi_key();
    repeat (3) run_scan(16'h8001);
    checks++; if (multi_key !== 1'b1 || key_held !== 1'b1) begin fails++; $display("FAIL multi_flags: got multi=%0b held=%0b expected 1/1", multi_key, key_held); end
    step();
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL multi_no_push: got %0d expected 0", fifo_count); end
    run_scan(16'h0);
    run_scan(16'h0);
    checks++; if (multi_key !== 1'b0 || key_held !== 1'b0) begin fails++; $display("FAIL multi_release: got multi=%0b held=%0b expected 0/0", multi_key, key_held); end
    run_scan(16'h8000);
    run_scan(16'h8000);
    step();
    checks++; if (fifo_count !== 3'd1 || key_code !== 4'd15) begin fails++; $display("FAIL multi_push15: got count=%0d code=%0d expected 1/15", fifo_count, key_code); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    m_q.delete(0);
    run_scan(16'h0);
    run_scan(16'h0);
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) press_release(k);
    step();
    checks++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (key_valid !== 1'b1 || key_code !== 4'(i + 1)) begin fails++; $display("FAIL ovf_pop%0d: got valid=%0b code=%0d expected 1/%0d", i, key_valid, key_code, i + 1); end
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      m_q.delete(0);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL ovf_clear: got ovf=%0b count=%0d expected 0/0", overflow, fifo_count); end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp4 [4] = '{4'd2, 4'd3, 4'd4, 4'd7};
    run_scan(16'h0);
    for (int k = 1; k <= 4; k++) press_release(k);
    run_scan(16'h0080);
    run_scan(16'h0080);
    checks++; if (fifo_count !== 3'd4 || key_code !== 4'd1) begin fails++; $display("FAIL full_pre: got count=%0d head=%0d expected 4/1", fifo_count, key_code); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    model_commit(1'b1);
    checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin fails++; $display("FAIL full_pushpop: got count=%0d ovf=%0b expected 4/0", fifo_count, overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (key_code !== exp4[i] || key_code !== m_q[0]) begin fails++; $display("FAIL full_head%0d: got %0d expected %0d", i, key_code, exp4[i]); end
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      m_q.delete(0);
    end
    run_scan(16'h0080);
    run_scan(16'h0);
    run_scan(16'h0);
  endtask

  task automatic test_reset_mid_scan();
    int n = 0;
    press_release(3);
    press_release(12);
    step();
    checks++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL rstmid_pre: got %0d expected 2", fifo_count); end
    while (cols !== 4'h4 && n < SCAN_BOUND) begin @(negedge clk); n++; end
    checks++; if (n >= SCAN_BOUND) begin fails++; $display("FAIL rstmid_col2_timeout: waited %0d cycles", n); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (cols !== 4'h0) begin fails++; $display("FAIL rstmid_cols: got %0h expected 0", cols); end
    checks++; if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL rstmid_fifo: got valid=%0b count=%0d expected 0/0", key_valid, fifo_count); end
    model_clear_scan();
    m_q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_disable();
    int n = 0;
    press_release(3);
    run_scan(16'h0020);
    run_scan(16'h0020);
    step();
    checks++; if (fifo_count !== 3'd2 || key_held !== 1'b1) begin fails++; $display("FAIL dis_pre: got count=%0d held=%0b expected 2/1", fifo_count, key_held); end
    while (cols !== 4'h2 && n < SCAN_BOUND) begin @(negedge clk); n++; end
    checks++; if (n >= SCAN_BOUND) begin fails++; $display("FAIL dis_col1_timeout: waited %0d cycles", n); end
    enable = 1'b0;
    @(negedge clk);
    model_clear_scan();
    checks++; if (cols !== 4'h0) begin fails++; $display("FAIL dis_cols: got %0h expected 0", cols); end
    checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL dis_held: got %0b expected 0", key_held); end
    checks++; if (fifo_count !== 3'd2 || key_code !== 4'd3) begin fails++; $display("FAIL dis_retained: got count=%0d head=%0d expected 2/3", fifo_count, key_code); end
    repeat (3) @(negedge clk);
    enable = 1'b1;
    run_scan(16'h0020);
    run_scan(16'h0020);
    run_scan(16'h0);
    run_scan(16'h0);
    step();
    checks++; if (fifo_count !== 3'(m_q.size())) begin fails++; $display("FAIL dis_repress_count: got %0d expected %0d", fifo_count, m_q.size()); end
    while (m_q.size() > 0) begin
      checks++; if (key_code !== m_q[0]) begin fails++; $display("FAIL dis_drain: got %0d expected %0d", key_code, m_q[0]); end
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      m_q.delete(0);
    end
  endtask

  task automatic test_random();
    logic [15:0] p;
    run_scan(16'h0);
    for (int s = 0; s < 24; s++) begin
      case ($urandom_range(0, 3))
        0: p = 16'h0;
        3: p = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: p = 16'h1 << $urandom_range(0, 15);
      endcase
      repeat ($urandom_range(1, 3)) begin
        run_scan(p);
        checks++; if (key_held !== (m_deb != 16'h0) || multi_key !== ($countones(m_deb) > 1)) begin fails++; $display("FAIL rand_flags: got held=%0b multi=%0b for map %04h", key_held, multi_key, m_deb); end
      end
    end
    run_scan(16'h0);
    run_scan(16'h0);
    step();
    checks++; if (fifo_count !== 3'(m_q.size()) || overflow !== m_ovf) begin fails++; $display("FAIL rand_fifo: got count=%0d ovf=%0b expected %0d/%0b", fifo_count, overflow, m_q.size(), m_ovf); end
    while (m_q.size() > 0) begin
      checks++; if (key_valid !== 1'b1 || key_code !== m_q[0]) begin fails++; $display("FAIL rand_drain: got valid=%0b code=%0d expected 1/%0d", key_valid, key_code, m_q[0]); end
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      m_q.delete(0);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || key_valid !== 1'b0) begin fails++; $display("FAIL rand_end: got ovf=%0b valid=%0b expected 0/0", overflow, key_valid); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_scan();
    test_disable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
